hazard_ctrl_unit: RTL

Parametrised pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It generates stall, flush and forwarding controls, and generalises single-cycle load-use stalling to a configurable multi-cycle load stall. It also adds branch-flush handling, a busy handshake for a multi-cycle execute unit (MDU: mul/div), and x0 hazard suppression. It sits beside the datapath and drives the F/D and D/E pipeline-register enables and clears, plus the E-stage operand muxes.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int LCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        MDU_BUSY
    } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage operand; the M stage wins over W and x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward controller for the 5-stage core with multi-cycle load and MDU stalls.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              result_src_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mdu_start_e,
    input  logic              mdu_done,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(LOAD_STALL - 1);

    state_t            state, state_nx;
    logic [LCNT_W-1:0] lcnt, lcnt_nx;
    logic              load_hz, mdu_hz;
    logic [1:0]        fwd_a, fwd_b;

    assign load_hz = result_src_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // Once busy, only mdu_done matters; a start paired with done never stalls.
    assign mdu_hz  = (state == MDU_BUSY) ? !mdu_done : (mdu_start_e && !mdu_done);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            lcnt  <= '0;
        end else begin
            state <= state_nx;
            lcnt  <= lcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        lcnt_nx  = lcnt;
        case (state)
            IDLE: begin
                if (mdu_hz) begin
                    state_nx = MDU_BUSY;
                end else if (load_hz && (LOAD_STALL > 1)) begin
                    state_nx = LOAD_WAIT;
                    lcnt_nx  = LCNT_LOAD;
                end
            end
            LOAD_WAIT: begin
                lcnt_nx = lcnt - LCNT_W'(1);
                if (mdu_hz) begin
                    state_nx = MDU_BUSY;
                    lcnt_nx  = '0;
                end else if (lcnt == LCNT_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            MDU_BUSY: begin
                if (mdu_done) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                lcnt_nx  = '0;
            end
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (mdu_hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if ((state == LOAD_WAIT) || ((state == IDLE) && load_hz)) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if ((state == IDLE) && pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_b)
    );

    assign forward_a_e = rst ? FWD_REG : fwd_a;
    assign forward_b_e = rst ? FWD_REG : fwd_b;

`ifdef HAZARD_PERF_EN
    // flush_d outside reset is exactly the branch-flush event.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_f && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            if (flush_d && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
